// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, index helper and types for the register file
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    function automatic int reg_aw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef logic [reg_aw(NREG_DEF)-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - ID/WB side bundle of the multi-port register file
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    parameter int NWR  = 2
);
    localparam int AW = reg_aw(NREG);

    logic [NRD*AW-1:0]   rs_id;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rs_busy;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   wr_rd;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NWR-1:0]      wr_clr;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                flush;
    logic                any_pending;
    logic [XLEN-1:0]     dbg_data;

    modport master (
        output rs_id, we, wr_rd, wr_data, wr_clr, iss_valid, iss_rd, flush,
        input  rd_data, rs_busy, any_pending, dbg_data
    );

    modport slave (
        input  rs_id, we, wr_rd, wr_data, wr_clr, iss_valid, iss_rd, flush,
        output rd_data, rs_busy, any_pending, dbg_data
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending bits for long-latency producers
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = reg_aw(NREG)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NRD*AW-1:0] rs_id,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] wr_rd,
    input  logic [NWR-1:0]    wr_clr,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    input  logic              flush,
    output logic [NRD-1:0]    rs_busy,
    output logic              any_pending
);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pend_nxt;

    function automatic logic is_zero(input logic [AW-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    function automatic logic clr_hit(input logic [AW-1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < NWR; w++) begin
            if (we[w] && wr_clr[w] && (wr_rd[w*AW +: AW] == idx)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Issue is applied after clears so a new producer overrides a completing one.
    always_comb begin
        pend_nxt = pending;
        if (flush) begin
            pend_nxt = '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (we[w] && wr_clr[w]) begin
                    pend_nxt[wr_rd[w*AW +: AW]] = 1'b0;
                end
            end
            if (iss_valid && !is_zero(iss_rd)) begin
                pend_nxt[iss_rd] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pending <= '0;
        end else begin
            pending <= pend_nxt;
        end
    end

    always_comb begin
        rs_busy = '0;
        for (int r = 0; r < NRD; r++) begin
            rs_busy[r] = pending[rs_id[r*AW +: AW]]
                       && !clr_hit(rs_id[r*AW +: AW])
                       && !is_zero(rs_id[r*AW +: AW]);
        end
    end

    assign any_pending = |pending;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port integer register file with bypass, zero reg and scoreboard
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int DBG_IDX  = 6
) (
    input  logic         clk,
    input  logic         rstn,
    regfile_mp_if.slave  bus
);

    localparam int AW = reg_aw(NREG);
    localparam logic [AW-1:0] DBG_A = AW'(DBG_IDX);

    logic [XLEN-1:0]     regs [NREG];
    logic [NRD*AW-1:0]   rs_id;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   wr_rd;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NRD*XLEN-1:0] rd_data;

    assign rs_id   = bus.rs_id;
    assign we      = bus.we;
    assign wr_rd   = bus.wr_rd;
    assign wr_data = bus.wr_data;

    function automatic logic is_zero(input logic [AW-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    // Later loop iterations override earlier ones, so the highest write port wins.
    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] rs);
        logic [XLEN-1:0] v;
        v = regs[rs];
        for (int w = 0; w < NWR; w++) begin
            if (we[w] && (wr_rd[w*AW +: AW] == rs)) begin
                v = wr_data[w*XLEN +: XLEN];
            end
        end
        if (is_zero(rs)) begin
            v = '0;
        end
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (we[w] && !is_zero(wr_rd[w*AW +: AW])) begin
                    regs[wr_rd[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int r = 0; r < NRD; r++) begin
            rd_data[r*XLEN +: XLEN] = read_port(rs_id[r*AW +: AW]);
        end
    end

    assign bus.rd_data  = rd_data;
    assign bus.dbg_data = regs[DBG_A];

    regfile_scoreboard #(
        .NREG     (NREG),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rstn        (rstn),
        .rs_id       (rs_id),
        .we          (we),
        .wr_rd       (wr_rd),
        .wr_clr      (bus.wr_clr),
        .iss_valid   (bus.iss_valid),
        .iss_rd      (bus.iss_rd),
        .flush       (bus.flush),
        .rs_busy     (bus.rs_busy),
        .any_pending (bus.any_pending)
    );

endmodule
